axil_uart_host_bridge: RTL and testbench
========================================

# axil_uart_host_bridge

AXI-Lite slave that turns each AXI-Lite write or read into a UART command frame, and turns the UART response frame back into B or R. It is the host-side counterpart of the UART-to-AXI-Lite master. It sits between an AXI-Lite initiator and the byte streams of an `axis_uart` instance: TX bytes go out on `m_axis`, RX bytes come in on `s_axis`. One transaction is outstanding at a time.

## Interface
- `UART_BYTE_START`, 8'hF0, frame start byte.
- `UART_BYTE_WR`, 8'hA1, write command byte.
- `UART_BYTE_RD`, 8'hA2, read command byte.
- `TIMEOUT_CYCLES`, 1_000_000, response timeout in `aclk` cycles (used only with the macro).
- `aclk` in 1: single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axil` `axil_if.s_axil`, 32-bit address / 32-bit data: AXI-Lite slave port.
- `m_axis` `axis_if.m_axis`, 8-bit `tdata`: bytes to the UART transmitter.
- `s_axis` `axis_if.s_axis`, 8-bit `tdata`: bytes from the UART receiver.

## Operation
- **Frame format.** Multi-byte fields are sent MSB first.
  - Write request: START, WR, addr[31:0], data[31:0] (10 bytes).
  - Read request: START, RD, addr (6 bytes).
  - Write response: START, WR, status.
  - Read response: START, RD, status, data[31:0].
  - status[1:0] maps directly to BRESP/RRESP; status[7:2] is ignored.
- **States:** IDLE, TX_START, TX_CMD, TX_ADDR, TX_DATA, RX_START, RX_CMD, RX_STATUS, RX_DATA, RESP.
- **IDLE.**
  - A write is accepted only when `awvalid` and `wvalid` are both high. `awready` and `wready` pulse together for one cycle.
  - A read is accepted when `arvalid` is high; `arready` pulses for one cycle.
  - Address and data are latched on acceptance.
  - `wstrb` is ignored: every write is a full word.
- **Arbitration.** Round-robin between write and read. If both are pending, the type not served last wins. After reset, write wins.
- **TX sequence.** TX_START → TX_CMD → TX_ADDR (4 bytes) → TX_DATA (4 bytes, writes only) → RX_START. Each state advances on `tvalid && tready`. A 2-bit byte counter indexes bytes 3..0.
- **RX_START.** `s_axis.tready`=1. Bytes other than START are discarded.
- **RX_CMD.** If the byte matches the issued command, go to RX_STATUS. Otherwise go back to RX_START.
- **RX_STATUS.** Latch the status byte. Writes go to RESP; reads go to RX_DATA (4 bytes shifted in MSB first).
- **RESP.**
  - Write: `bvalid`=1 with `bresp`=status[1:0].
  - Read: `rvalid`=1 with `rresp`=status[1:0] and the captured `rdata`.
  - Valid is held until the ready handshake, then the FSM returns to IDLE.
- `s_axis.tready`=0 outside the RX states, so stray RX bytes are backpressured and not dropped.

## Timing
- **Reset values (all outputs 0):**
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid`
  - `bresp`, `rresp`, `rdata`
  - `m_axis.tvalid`, `m_axis.tdata`, `s_axis.tready`
  - FSM in IDLE; round-robin pointer selects write.
- **Output registers.** All outputs are registered. `m_axis.tvalid`/`tdata` stay stable until `tready`.
- **Latency.**
  - The first byte (START) is valid the cycle after the AXI-Lite accept.
  - With `tready` held at 1: a write frame takes 10 cycles, a read frame 6.
  - `bvalid`/`rvalid` rise the cycle after the last response byte handshake.
- **Back-to-back.** The next accept can occur the cycle after the B or R handshake.
- **Mid-frame reset.** Asserting `aresetn` low mid-frame abandons the frame immediately. No partial-frame cleanup is performed.
- **Outstanding limit.** New AW/W/AR are not accepted outside IDLE; their ready signals stay 0.

## Configuration
- `AXIL_UART_TIMEOUT_EN` **defined:**
  - A counter runs in the RX states and is cleared on every accepted RX byte.
  - When it reaches `TIMEOUT_CYCLES`-1, the FSM goes to RESP with resp=2'b10 (SLVERR) and `rdata`=0.
- `AXIL_UART_TIMEOUT_EN` **undefined:** the FSM waits in the RX states indefinitely. No counter logic is synthesized.

## Structure
- Package `axil_uart_pkg` holds:
  - the state enum;
  - default START/WR/RD byte constants;
  - resp codes (OKAY=2'b00, SLVERR=2'b10);
  - frame byte-count constants (write 10, read 6).
- Sub-module `axil_uart_timeout`: a loadable down-counter with a clear input and an expiry pulse. It is instantiated only under `AXIL_UART_TIMEOUT_EN`.

## Test plan
- **Write.** Write addr 32'h0000_1000, data 32'hDEAD_BEEF, `tready`=1.
  - `m_axis` must carry F0 A1 00 00 10 00 DE AD BE EF.
  - Drive RX F0 A1 00; `bvalid` must assert with `bresp`=00.
- **Read.** Read addr 32'h0000_2004.
  - TX must be F0 A2 00 00 20 04.
  - Drive RX F0 A2 02 12 34 56 78; `rvalid` must assert with `rresp`=10 and `rdata`=32'h1234_5678.
- **Resync.** Drive RX garbage 55 F0 A2 before the write response F0 A1 00. The garbage must be discarded and `bresp`=00.
- **Arbitration.** AW+W and AR valid in the same cycle after reset.
  - The write is served first, then the read.
  - With `tready` toggling 1/0, each byte must be held stable while `tready`=0.
- **Reset.** Assert `aresetn` low after the 3rd TX byte. All outputs must go to 0 and the FSM to IDLE. A fresh write after release must emit a complete frame.
- **Timeout.** With `AXIL_UART_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=100, send a read and give no RX bytes. `rvalid` must assert with `rresp`=10 and `rdata`=0 at 100 cycles after the last TX byte.

Source files
------------

// File: rtl/axil_uart_pkg.sv
// Shared constants, state encoding and helpers for the AXI-Lite to UART host bridge.
// The optional response timeout is enabled with AXIL_UART_TIMEOUT_EN.
package axil_uart_pkg;

    localparam logic [7:0] DEF_BYTE_START = 8'hF0;
    localparam logic [7:0] DEF_BYTE_WR    = 8'hA1;
    localparam logic [7:0] DEF_BYTE_RD    = 8'hA2;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam int WR_FRAME_BYTES = 10;
    localparam int RD_FRAME_BYTES = 6;

    // Plain localparam encoding keeps the state register readable by older tools.
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_TX_START  = 4'd1;
    localparam state_t ST_TX_CMD    = 4'd2;
    localparam state_t ST_TX_ADDR   = 4'd3;
    localparam state_t ST_TX_DATA   = 4'd4;
    localparam state_t ST_RX_START  = 4'd5;
    localparam state_t ST_RX_CMD    = 4'd6;
    localparam state_t ST_RX_STATUS = 4'd7;
    localparam state_t ST_RX_DATA   = 4'd8;
    localparam state_t ST_RESP      = 4'd9;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/axil_uart_host_bridge_if.sv
// AXI-Lite (32/32) and 8-bit AXI-Stream interfaces used by the UART host bridge.
// Bus widths are fixed; the optional timeout macro AXIL_UART_TIMEOUT_EN does not affect them.
interface axil_if;
    import axil_uart_pkg::*;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    resp_t       bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    resp_t       rresp;
    logic        rvalid;
    logic        rready;

    modport m_axil (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s_axil (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface axis_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport m_axis (output tdata, tvalid, input tready);
    modport s_axis (input tdata, tvalid, output tready);
endinterface

// File: rtl/axil_uart_timeout.sv
// Loadable down-counter: reloads on clear, counts while enabled, flags expiry when it hits zero.
// Only instantiated when AXIL_UART_TIMEOUT_EN is defined.
module axil_uart_timeout
    import axil_uart_pkg::*;
#(
    parameter int LOAD_VALUE = 999_999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'(LOAD_VALUE);
        end else if (clear) begin
            count <= 32'(LOAD_VALUE);
        end else if (enable && (count != 32'd0)) begin
            count <= count - 32'd1;
        end
    end

    // A clear in the same cycle wins, so an arriving byte always rescues the transaction.
    assign expired = enable && !clear && (count == 32'd0);

endmodule

// File: rtl/axil_uart_host_bridge.sv
// AXI-Lite slave that serialises each transaction into a UART command frame and decodes the reply.
// Define AXIL_UART_TIMEOUT_EN to abort stalled responses with SLVERR after TIMEOUT_CYCLES.
module axil_uart_host_bridge
   import axil_uart_pkg::*;
#(
   parameter logic [7:0] UART_BYTE_START = DEF_BYTE_START,
   parameter logic [7:0] UART_BYTE_WR    = DEF_BYTE_WR,
   parameter logic [7:0] UART_BYTE_RD    = DEF_BYTE_RD,
   parameter int         TIMEOUT_CYCLES  = 1_000_000
) (
   input  logic   aclk,
   input  logic   aresetn,
   axil_if.s_axil s_axil,
   axis_if.m_axis m_axis,
   axis_if.s_axis s_axis
);

   state_t      state;
   logic        is_write;
   logic        rr_read_next;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  byte_cnt;

   logic        awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
   resp_t       bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic        tx_valid_q;
   logic [7:0]  tx_data_q;
   logic        rx_ready_q;

   logic        tx_hs, rx_hs, wr_pending, grant_wr, grant_rd, timed_out;
   logic [7:0]  cmd_byte;
   logic        unused_wstrb;

   assign tx_hs        = tx_valid_q && m_axis.tready;
   assign rx_hs        = rx_ready_q && s_axis.tvalid;
   assign wr_pending   = s_axil.awvalid && s_axil.wvalid;
   assign grant_wr     = wr_pending && (!s_axil.arvalid || !rr_read_next);
   assign grant_rd     = s_axil.arvalid && (!wr_pending || rr_read_next);
   assign cmd_byte     = is_write ? UART_BYTE_WR : UART_BYTE_RD;
   assign unused_wstrb = ^s_axil.wstrb;

`ifdef AXIL_UART_TIMEOUT_EN
   axil_uart_timeout #(
      .LOAD_VALUE (TIMEOUT_CYCLES - 1)
   ) u_timeout (
      .clk     (aclk),
      .rst_n   (aresetn),
      .clear   (!rx_ready_q || rx_hs),
      .enable  (rx_ready_q),
      .expired (timed_out)
   );
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= ST_IDLE;
         is_write     <= 1'b0;
         rr_read_next <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         byte_cnt     <= '0;
         awready_q    <= 1'b0;
         wready_q     <= 1'b0;
         arready_q    <= 1'b0;
         bvalid_q     <= 1'b0;
         rvalid_q     <= 1'b0;
         bresp_q      <= RESP_OKAY;
         rresp_q      <= RESP_OKAY;
         rdata_q      <= '0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         rx_ready_q   <= 1'b0;
      end else begin
         case (state)
            // Ready is raised one cycle, the handshake completes in the next.
            ST_IDLE: begin
               if (awready_q) begin
                  awready_q    <= 1'b0;
                  wready_q     <= 1'b0;
                  addr_q       <= s_axil.awaddr;
                  wdata_q      <= s_axil.wdata;
                  is_write     <= 1'b1;
                  rr_read_next <= 1'b1;
                  tx_valid_q   <= 1'b1;
                  tx_data_q    <= UART_BYTE_START;
                  state        <= ST_TX_START;
               end else if (arready_q) begin
                  arready_q    <= 1'b0;
                  addr_q       <= s_axil.araddr;
                  is_write     <= 1'b0;
                  rr_read_next <= 1'b0;
                  tx_valid_q   <= 1'b1;
                  tx_data_q    <= UART_BYTE_START;
                  state        <= ST_TX_START;
               end else begin
                  awready_q <= grant_wr;
                  wready_q  <= grant_wr;
                  arready_q <= grant_rd;
               end
            end
            ST_TX_START: begin
               if (tx_hs) begin
                  tx_data_q <= cmd_byte;
                  state     <= ST_TX_CMD;
               end
            end
            ST_TX_CMD: begin
               if (tx_hs) begin
                  byte_cnt  <= 2'd3;
                  tx_data_q <= word_byte(addr_q, 2'd3);
                  state     <= ST_TX_ADDR;
               end
            end
            ST_TX_ADDR, ST_TX_DATA: begin
               if (tx_hs) begin
                  if (byte_cnt != 2'd0) begin
                     byte_cnt  <= byte_cnt - 2'd1;
                     tx_data_q <= word_byte((state == ST_TX_ADDR) ? addr_q : wdata_q,
                                            byte_cnt - 2'd1);
                  end else if ((state == ST_TX_ADDR) && is_write) begin
                     byte_cnt  <= 2'd3;
                     tx_data_q <= word_byte(wdata_q, 2'd3);
                     state     <= ST_TX_DATA;
                  end else begin
                     tx_valid_q <= 1'b0;
                     rx_ready_q <= 1'b1;
                     state      <= ST_RX_START;
                  end
               end
            end
            // Any unexpected byte drops the parser back to hunting for START.
            ST_RX_START, ST_RX_CMD, ST_RX_STATUS, ST_RX_DATA: begin
               if (timed_out) begin
                  rx_ready_q <= 1'b0;
                  rdata_q    <= '0;
                  state      <= ST_RESP;
                  if (is_write) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= RESP_SLVERR;
                  end else begin
                     rvalid_q <= 1'b1;
                     rresp_q  <= RESP_SLVERR;
                  end
               end else if (rx_hs) begin
                  case (state)
                     ST_RX_START: begin
                        if (s_axis.tdata == UART_BYTE_START) state <= ST_RX_CMD;
                     end
                     ST_RX_CMD: begin
                        state <= (s_axis.tdata == cmd_byte) ? ST_RX_STATUS : ST_RX_START;
                     end
                     ST_RX_STATUS: begin
                        if (is_write) begin
                           bresp_q    <= s_axis.tdata[1:0];
                           bvalid_q   <= 1'b1;
                           rx_ready_q <= 1'b0;
                           state      <= ST_RESP;
                        end else begin
                           rresp_q  <= s_axis.tdata[1:0];
                           byte_cnt <= 2'd3;
                           state    <= ST_RX_DATA;
                        end
                     end
                     default: begin
                        rdata_q  <= {rdata_q[23:0], s_axis.tdata};
                        byte_cnt <= byte_cnt - 2'd1;
                        if (byte_cnt == 2'd0) begin
                           rvalid_q   <= 1'b1;
                           rx_ready_q <= 1'b0;
                           state      <= ST_RESP;
                        end
                     end
                  endcase
               end
            end
            // Arbitrating on the response handshake lets the next accept follow immediately.
            ST_RESP: begin
               if ((is_write && bvalid_q && s_axil.bready) ||
                   (!is_write && rvalid_q && s_axil.rready)) begin
                  bvalid_q  <= 1'b0;
                  rvalid_q  <= 1'b0;
                  awready_q <= grant_wr;
                  wready_q  <= grant_wr;
                  arready_q <= grant_rd;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign s_axil.awready = awready_q;
   assign s_axil.wready  = wready_q;
   assign s_axil.arready = arready_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rdata   = rdata_q;
   assign m_axis.tvalid  = tx_valid_q;
   assign m_axis.tdata   = tx_data_q;
   assign s_axis.tready  = rx_ready_q;

endmodule

// File: tb/tb_axil_uart_host_bridge.sv
// Directed bench for axil_uart_host_bridge: vector table plus arbitration, reset and timeout sequences.
// The timeout sequence is compiled only when AXIL_UART_TIMEOUT_EN is defined.
module tb_axil_uart_host_bridge;
   import axil_uart_pkg::*;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   always #5 aclk = ~aclk;

   axil_if axil ();
   axis_if tx ();
   axis_if rx ();

   axil_uart_host_bridge #(
      .TIMEOUT_CYCLES (100)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_axil  (axil.s_axil),
      .m_axis  (tx.m_axis),
      .s_axis  (rx.s_axis)
   );

   // Frames are left-aligned: byte 0 of the frame sits in bits [79:72].
   typedef struct packed {
      logic        is_write;
      logic        toggle;
      logic [31:0] addr;
      logic [31:0] data;
      logic [79:0] tx;
      logic [3:0]  tx_len;
      logic [79:0] rx;
      logic [3:0]  rx_len;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [5];

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, " awready"}, 32'(axil.awready), 32'd0);
      checkOutput({tag, " wready"},  32'(axil.wready),  32'd0);
      checkOutput({tag, " arready"}, 32'(axil.arready), 32'd0);
      checkOutput({tag, " bvalid"},  32'(axil.bvalid),  32'd0);
      checkOutput({tag, " rvalid"},  32'(axil.rvalid),  32'd0);
      checkOutput({tag, " bresp"},   32'(axil.bresp),   32'd0);
      checkOutput({tag, " rresp"},   32'(axil.rresp),   32'd0);
      checkOutput({tag, " rdata"},   axil.rdata,        32'd0);
      checkOutput({tag, " tx tvalid"}, 32'(tx.tvalid),  32'd0);
      checkOutput({tag, " tx tdata"},  32'(tx.tdata),   32'd0);
      checkOutput({tag, " rx tready"}, 32'(rx.tready),  32'd0);
   endtask

   task automatic reset_dut();
      aresetn = 1'b0;
      step();
      step();
      aresetn = 1'b1;
      step();
   endtask

   task automatic wait_accept(input logic want_write);
      int n = 0;
      while (!(want_write ? axil.awready : axil.arready) && n < 50) begin
         step();
         n++;
      end
      checkOutput(want_write ? "aw accept" : "ar accept", 32'(n < 50), 32'd1);
      if (want_write) checkOutput("wready with awready", 32'(axil.wready), 32'd1);
      step();
      axil.awvalid = 1'b0;
      axil.wvalid  = 1'b0;
      axil.arvalid = 1'b0;
   endtask

   task automatic axil_write(input logic [31:0] a, input logic [31:0] d);
      axil.awaddr  = a;
      axil.wdata   = d;
      axil.wstrb   = 4'h3;
      axil.awvalid = 1'b1;
      axil.wvalid  = 1'b1;
      wait_accept(1'b1);
   endtask

   task automatic axil_read(input logic [31:0] a);
      axil.araddr  = a;
      axil.arvalid = 1'b1;
      wait_accept(1'b0);
   endtask

   task automatic capture_tx(input logic [79:0] exp, input int len, input logic toggle);
      int         n = 0;
      int         cyc = 0;
      logic       held_valid = 1'b0;
      logic [7:0] held = 8'h00;
      while (n < len && cyc < 200) begin
         if (held_valid) begin
            checkOutput("tx byte held", {23'd0, tx.tvalid, tx.tdata}, {24'd1, held});
            held_valid = 1'b0;
         end
         tx.tready = toggle ? cyc[0] : 1'b1;
         if (tx.tvalid && tx.tready) begin
            checkOutput($sformatf("tx byte %0d", n), 32'(tx.tdata), 32'(exp[79 - 8*n -: 8]));
            n++;
         end else if (tx.tvalid) begin
            held       = tx.tdata;
            held_valid = 1'b1;
         end
         step();
         cyc++;
      end
      tx.tready = 1'b0;
      checkOutput("tx frame length", 32'(n), 32'(len));
      if (!toggle) checkOutput("tx frame cycles", 32'(cyc), 32'(len));
      checkOutput("tx idle after frame", 32'(tx.tvalid), 32'd0);
   endtask

   task automatic send_rx(input logic [79:0] bytes, input int len);
      for (int i = 0; i < len; i++) begin
         int w = 0;
         rx.tdata  = bytes[79 - 8*i -: 8];
         rx.tvalid = 1'b1;
         while (!rx.tready && w < 50) begin
            step();
            w++;
         end
         if (w >= 50) checkOutput("rx tready wait", 32'(rx.tready), 32'd1);
         step();
      end
      rx.tvalid = 1'b0;
      rx.tdata  = 8'h00;
   endtask

   task automatic check_resp(input logic is_write, input logic [1:0] resp, input logic [31:0] rdata);
      int n = 0;
      if (is_write) begin
         checkOutput("bvalid latency", 32'(axil.bvalid), 32'd1);
         while (!axil.bvalid && n < 50) begin step(); n++; end
         checkOutput("bresp", 32'(axil.bresp), 32'(resp));
         checkOutput("rvalid quiet on write", 32'(axil.rvalid), 32'd0);
         axil.bready = 1'b1;
         step();
         axil.bready = 1'b0;
         checkOutput("bvalid dropped", 32'(axil.bvalid), 32'd0);
      end else begin
         checkOutput("rvalid latency", 32'(axil.rvalid), 32'd1);
         while (!axil.rvalid && n < 50) begin step(); n++; end
         checkOutput("rresp", 32'(axil.rresp), 32'(resp));
         checkOutput("rdata", axil.rdata, rdata);
         checkOutput("bvalid quiet on read", 32'(axil.bvalid), 32'd0);
         axil.rready = 1'b1;
         step();
         axil.rready = 1'b0;
         checkOutput("rvalid dropped", 32'(axil.rvalid), 32'd0);
      end
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v = vecs[idx];
      if (v.is_write) axil_write(v.addr, v.data);
      else            axil_read(v.addr);
      checkOutput("start byte latency", {23'd0, tx.tvalid, tx.tdata}, {24'd1, DEF_BYTE_START});
      capture_tx(v.tx, int'(v.tx_len), v.toggle);
      send_rx(v.rx, int'(v.rx_len));
      check_resp(v.is_write, v.resp, v.rdata);
   endtask

   // Main sequence: vector table, arbitration, mid-frame reset and optional timeout.
   initial begin
      axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0;
      axil.bready = 1'b0; axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
      tx.tready = 1'b0;
      rx.tvalid = 1'b0;
      rx.tdata  = 8'h00;

      vecs[0] = '{is_write: 1'b1, toggle: 1'b0, addr: 32'h0000_1000, data: 32'hDEAD_BEEF,
                  tx: 80'hF0_A1_00_00_10_00_DE_AD_BE_EF, tx_len: 4'(WR_FRAME_BYTES),
                  rx: 80'hF0_A1_00_00_00_00_00_00_00_00, rx_len: 4'd3,
                  resp: 2'b00, rdata: 32'h0};
      vecs[1] = '{is_write: 1'b0, toggle: 1'b0, addr: 32'h0000_2004, data: 32'h0,
                  tx: 80'hF0_A2_00_00_20_04_00_00_00_00, tx_len: 4'(RD_FRAME_BYTES),
                  rx: 80'hF0_A2_02_12_34_56_78_00_00_00, rx_len: 4'd7,
                  resp: 2'b10, rdata: 32'h1234_5678};
      vecs[2] = '{is_write: 1'b1, toggle: 1'b0, addr: 32'h0000_0040, data: 32'h0102_0304,
                  tx: 80'hF0_A1_00_00_00_40_01_02_03_04, tx_len: 4'(WR_FRAME_BYTES),
                  rx: 80'h55_F0_A2_F0_A1_00_00_00_00_00, rx_len: 4'd6,
                  resp: 2'b00, rdata: 32'h0};
      vecs[3] = '{is_write: 1'b0, toggle: 1'b1, addr: 32'hA5A5_0008, data: 32'h0,
                  tx: 80'hF0_A2_A5_A5_00_08_00_00_00_00, tx_len: 4'(RD_FRAME_BYTES),
                  rx: 80'hF0_A2_FD_CA_FE_BA_BE_00_00_00, rx_len: 4'd7,
                  resp: 2'b01, rdata: 32'hCAFE_BABE};
      vecs[4] = '{is_write: 1'b1, toggle: 1'b1, addr: 32'hFFFF_FFFC, data: 32'h0000_0000,
                  tx: 80'hF0_A1_FF_FF_FF_FC_00_00_00_00, tx_len: 4'(WR_FRAME_BYTES),
                  rx: 80'hF0_A1_03_00_00_00_00_00_00_00, rx_len: 4'd3,
                  resp: 2'b11, rdata: 32'h0};

      step();
      check_all_zero("reset");
      aresetn = 1'b1;
      step();

      for (int i = 0; i < 5; i++) applyStimulus(i);

      // Simultaneous write and read straight out of reset: write first, then round-robin.
      reset_dut();
      axil.awaddr = 32'h0000_3000; axil.wdata = 32'h5555_AAAA; axil.wstrb = 4'hF;
      axil.araddr = 32'h0000_3008;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
      step();
      checkOutput("arb awready", 32'(axil.awready), 32'd1);
      checkOutput("arb wready",  32'(axil.wready),  32'd1);
      checkOutput("arb arready", 32'(axil.arready), 32'd0);
      step();
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      checkOutput("arb start byte", {23'd0, tx.tvalid, tx.tdata}, {24'd1, DEF_BYTE_START});
      capture_tx(80'hF0_A1_00_00_30_00_55_55_AA_AA, WR_FRAME_BYTES, 1'b1);
      checkOutput("arready blocked while busy", 32'(axil.arready), 32'd0);
      send_rx(80'hF0_A1_00_00_00_00_00_00_00_00, 3);
      axil.awaddr = 32'h0000_3010; axil.wdata = 32'h0000_0001;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1;
      check_resp(1'b1, 2'b00, 32'h0);
      checkOutput("rr read wins arready", 32'(axil.arready), 32'd1);
      checkOutput("rr read wins awready", 32'(axil.awready), 32'd0);
      step();
      axil.arvalid = 1'b0;
      capture_tx(80'hF0_A2_00_00_30_08_00_00_00_00, RD_FRAME_BYTES, 1'b0);
      send_rx(80'hF0_A2_00_00_00_00_2A_00_00_00, 7);
      check_resp(1'b0, 2'b00, 32'h0000_002A);
      checkOutput("b2b awready after R", 32'(axil.awready), 32'd1);
      step();
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      capture_tx(80'hF0_A1_00_00_30_10_00_00_00_01, WR_FRAME_BYTES, 1'b0);
      send_rx(80'hF0_A1_00_00_00_00_00_00_00_00, 3);
      check_resp(1'b1, 2'b00, 32'h0);

      // Reset in the middle of a write frame, then a complete fresh write.
      axil_write(32'h0000_1000, 32'hDEAD_BEEF);
      tx.tready = 1'b1;
      step(); step(); step();
      checkOutput("mid-frame tvalid", 32'(tx.tvalid), 32'd1);
      aresetn = 1'b0;
      #1;
      check_all_zero("mid-frame reset");
      tx.tready = 1'b0;
      step(); step();
      aresetn = 1'b1;
      step();
      applyStimulus(0);

`ifdef AXIL_UART_TIMEOUT_EN
      begin
         int n = 0;
         axil_read(32'h0000_2004);
         capture_tx(80'hF0_A2_00_00_20_04_00_00_00_00, RD_FRAME_BYTES, 1'b0);
         while (!axil.rvalid && n < 300) begin
            step();
            n++;
         end
         checkOutput("timeout cycles", 32'(n), 32'd100);
         checkOutput("timeout rresp", 32'(axil.rresp), 32'(RESP_SLVERR));
         checkOutput("timeout rdata", axil.rdata, 32'h0);
         axil.rready = 1'b1;
         step();
         axil.rready = 1'b0;
         checkOutput("timeout rvalid dropped", 32'(axil.rvalid), 32'd0);
      end
`endif

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
